// File: rtl/mem_access_ctrl_if.sv
// Data-RAM request/acknowledge port shared by the MEM-stage sequencer (master) and the RAM (slave).
interface mem_access_ctrl_if;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = DATA_W / 8;

    logic                dram_req_o;
    logic                dram_we_o;
    logic [ADDR_W-1:0]   dram_addr_o;
    logic [DATA_W-1:0]   dram_wdata_o;
    logic [STRB_W-1:0]   dram_wstrb_o;
    logic                dram_ack_i;
    logic [DATA_W-1:0]   dram_rdata_i;

    modport master (
        output dram_req_o, dram_we_o, dram_addr_o, dram_wdata_o, dram_wstrb_o,
        input  dram_ack_i, dram_rdata_i
    );

    modport slave (
        input  dram_req_o, dram_we_o, dram_addr_o, dram_wdata_o, dram_wstrb_o,
        output dram_ack_i, dram_rdata_i
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store sequencer: one blocking data-RAM transaction per memory op,
// load extension and store lane replication, with pipeline stall and exception reporting.
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] store_data_i,
    input  logic [4:0]  rd_addr_i,
    input  logic        wreg_i,
    input  logic [31:0] wdata_i,
    mem_access_ctrl_if.master dram,
    output logic        stall_req_o,
    output logic [4:0]  rd_addr_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic [4:0]  mem_back_rd_addr_o,
    output logic        mem_back_wreg_o,
    output logic [31:0] mem_back_wdata_o,
    output logic [1:0]  mem_exc_o
);
    localparam int unsigned CNT_W = 8;

    localparam logic [1:0] EXC_NONE    = 2'b00;
    localparam logic [1:0] EXC_MISALGN = 2'b01;
    localparam logic [1:0] EXC_TIMEOUT = 2'b10;
    localparam logic [1:0] EXC_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [29:0]        waddr_q;
    logic               we_q;
    logic [3:0]         wstrb_q;
    logic [31:0]        wdata_q;
    logic [2:0]         f3_q;
    logic [1:0]         lane_q;
    logic               req_q;
    logic               tmo_q;
    logic [31:0]        ld_data_q;

    logic               f3_legal_c;
    logic               misaligned_c;
    logic               start_c;
    logic [31:0]        st_wdata_c;
    logic [3:0]         st_wstrb_c;
    logic [7:0]         ld_byte_c;
    logic [15:0]        ld_half_c;
    logic [31:0]        ld_fmt_c;

    // Legality and alignment of the incoming op; funct3 legality wins over alignment.
    always_comb begin
        f3_legal_c   = 1'b0;
        misaligned_c = 1'b0;
        if (mem_we_i)
            f3_legal_c = (funct3_i == 3'b000) || (funct3_i == 3'b001) || (funct3_i == 3'b010);
        else
            f3_legal_c = (funct3_i == 3'b000) || (funct3_i == 3'b001) || (funct3_i == 3'b010) ||
                         (funct3_i == 3'b100) || (funct3_i == 3'b101);
        case (funct3_i[1:0])
            2'b01:   misaligned_c = addr_i[0];
            2'b10:   misaligned_c = (addr_i[1:0] != 2'b00);
            default: misaligned_c = 1'b0;
        endcase
        start_c = mem_req_i && f3_legal_c && !misaligned_c;
    end

    // Store lane replication and byte strobes.
    always_comb begin
        st_wdata_c = store_data_i;
        st_wstrb_c = 4'b1111;
        case (funct3_i[1:0])
            2'b00: begin
                st_wdata_c = {4{store_data_i[7:0]}};
                st_wstrb_c = 4'b0001 << addr_i[1:0];
            end
            2'b01: begin
                st_wdata_c = {2{store_data_i[15:0]}};
                st_wstrb_c = 4'b0011 << addr_i[1:0];
            end
            default: begin
                st_wdata_c = store_data_i;
                st_wstrb_c = 4'b1111;
            end
        endcase
    end

    // Load byte/halfword selection and extension from the latched width code and lane.
    always_comb begin
        ld_byte_c = 8'(dram.dram_rdata_i >> {lane_q, 3'b000});
        ld_half_c = lane_q[1] ? dram.dram_rdata_i[31:16] : dram.dram_rdata_i[15:0];
        case (f3_q)
            3'b000:  ld_fmt_c = {{24{ld_byte_c[7]}}, ld_byte_c};
            3'b001:  ld_fmt_c = {{16{ld_half_c[15]}}, ld_half_c};
            3'b100:  ld_fmt_c = {24'h0, ld_byte_c};
            3'b101:  ld_fmt_c = {16'h0, ld_half_c};
            default: ld_fmt_c = dram.dram_rdata_i;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            waddr_q   <= '0;
            we_q      <= 1'b0;
            wstrb_q   <= 4'b0000;
            wdata_q   <= '0;
            f3_q      <= 3'b000;
            lane_q    <= 2'b00;
            req_q     <= 1'b0;
            tmo_q     <= 1'b0;
            ld_data_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_c) begin
                        waddr_q <= addr_i[31:2];
                        we_q    <= mem_we_i;
                        wstrb_q <= mem_we_i ? st_wstrb_c : 4'b0000;
                        wdata_q <= st_wdata_c;
                        f3_q    <= funct3_i;
                        lane_q  <= addr_i[1:0];
                        cnt_q   <= '0;
                        tmo_q   <= 1'b0;
                        req_q   <= 1'b1;
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (dram.dram_ack_i) begin
                        ld_data_q <= ld_fmt_c;
                        req_q     <= 1'b0;
                        state_q   <= DONE;
                    end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
                        tmo_q   <= 1'b1;
                        req_q   <= 1'b0;
                        state_q <= DONE;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dram.dram_req_o   = req_q;
    assign dram.dram_we_o    = we_q;
    assign dram.dram_addr_o  = {waddr_q, 2'b00};
    assign dram.dram_wdata_o = wdata_q;
    assign dram.dram_wstrb_o = wstrb_q;

    // Write-back view: passthrough in IDLE, suppressed while stalled or on exceptions.
    always_comb begin
        stall_req_o = 1'b0;
        rd_addr_o   = rd_addr_i;
        wreg_o      = 1'b0;
        wdata_o     = wdata_i;
        mem_exc_o   = EXC_NONE;
        if (rst) begin
            case (state_q)
                IDLE: begin
                    if (!mem_req_i)
                        wreg_o = wreg_i;
                    else if (!f3_legal_c)
                        mem_exc_o = EXC_ILLEGAL;
                    else if (misaligned_c)
                        mem_exc_o = EXC_MISALGN;
                    else
                        stall_req_o = 1'b1;
                end
                REQ: stall_req_o = 1'b1;
                DONE: begin
                    if (tmo_q) begin
                        mem_exc_o = EXC_TIMEOUT;
                    end else if (!we_q) begin
                        wreg_o  = wreg_i;
                        wdata_o = ld_data_q;
                    end
                end
                default: stall_req_o = 1'b0;
            endcase
        end
    end

    assign mem_back_rd_addr_o = rd_addr_o;
    assign mem_back_wreg_o    = wreg_o;
    assign mem_back_wdata_o   = wdata_o;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: each op pushes its expected result, which is popped
// and compared when the sequencer releases the stall.
module tb_mem_access_ctrl;
    localparam int unsigned TMO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req_i, mem_we_i, wreg_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i, store_data_i, wdata_i;
    logic [4:0]  rd_addr_i;
    logic        stall_req_o, wreg_o, mem_back_wreg_o;
    logic [4:0]  rd_addr_o, mem_back_rd_addr_o;
    logic [31:0] wdata_o, mem_back_wdata_o;
    logic [1:0]  mem_exc_o;

    mem_access_ctrl_if dram_bus();

    mem_access_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .funct3_i(funct3_i),
        .addr_i(addr_i), .store_data_i(store_data_i), .rd_addr_i(rd_addr_i),
        .wreg_i(wreg_i), .wdata_i(wdata_i),
        .dram(dram_bus),
        .stall_req_o(stall_req_o),
        .rd_addr_o(rd_addr_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
        .mem_back_rd_addr_o(mem_back_rd_addr_o), .mem_back_wreg_o(mem_back_wreg_o),
        .mem_back_wdata_o(mem_back_wdata_o),
        .mem_exc_o(mem_exc_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic        mreq;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [4:0]  rd;
        logic        wreg;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          ack_at;   // REQ cycle index that sees ack, -1 for never
    } stim_t;

    typedef struct {
        int          stalls;
        int          reqs;
        logic [4:0]  rd;
        logic        wreg;
        logic [31:0] wdata;
        logic [1:0]  exc;
        bit          bus;
        logic [31:0] daddr;
        logic        dwe;
        logic [3:0]  dstrb;
        bit          chk_dwdata;
        logic [31:0] dwdata;
    } exp_t;

    exp_t exp_q[$];

    function automatic stim_t mk_stim(input logic mreq, input logic we, input logic [2:0] f3,
                                      input logic [31:0] addr, input logic [31:0] sdata,
                                      input logic [4:0] rd, input logic wreg,
                                      input logic [31:0] wdata, input logic [31:0] rdata,
                                      input int ack_at);
        stim_t s;
        s.mreq = mreq; s.we = we; s.f3 = f3; s.addr = addr; s.sdata = sdata;
        s.rd = rd; s.wreg = wreg; s.wdata = wdata; s.rdata = rdata; s.ack_at = ack_at;
        return s;
    endfunction

    function automatic exp_t mk_exp(input int stalls, input int reqs, input logic [4:0] rd,
                                    input logic wreg, input logic [31:0] wdata,
                                    input logic [1:0] exc);
        exp_t e;
        e.stalls = stalls; e.reqs = reqs; e.rd = rd; e.wreg = wreg; e.wdata = wdata; e.exc = exc;
        e.bus = 1'b0; e.daddr = '0; e.dwe = 1'b0; e.dstrb = '0; e.chk_dwdata = 1'b0; e.dwdata = '0;
        return e;
    endfunction

    function automatic exp_t with_bus(input exp_t ein, input logic [31:0] daddr, input logic dwe,
                                      input logic [3:0] dstrb, input bit chk,
                                      input logic [31:0] dwdata);
        exp_t e;
        e = ein;
        e.bus = 1'b1; e.daddr = daddr; e.dwe = dwe; e.dstrb = dstrb;
        e.chk_dwdata = chk; e.dwdata = dwdata;
        return e;
    endfunction

    // Drive one op, answer the bus, and score the cycle in which the stall is released.
    task automatic run_op(input string tag, input stim_t s, input exp_t e, input bit gap);
        int          stalls;
        int          reqs;
        bit          done;
        bit          moved;
        logic [31:0] a0, w0;
        logic        we0;
        logic [3:0]  s0;
        exp_t        got;
        stalls = 0; reqs = 0; done = 1'b0; moved = 1'b0;
        a0 = '0; w0 = '0; we0 = 1'b0; s0 = '0;
        @(posedge clk); #1;
        mem_req_i = s.mreq; mem_we_i = s.we; funct3_i = s.f3; addr_i = s.addr;
        store_data_i = s.sdata; rd_addr_i = s.rd; wreg_i = s.wreg; wdata_i = s.wdata;
        dram_bus.dram_rdata_i = s.rdata;
        exp_q.push_back(e);
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (dram_bus.dram_req_o) begin
                if (reqs == 0) begin
                    a0 = dram_bus.dram_addr_o; we0 = dram_bus.dram_we_o;
                    s0 = dram_bus.dram_wstrb_o; w0 = dram_bus.dram_wdata_o;
                end else if (a0 !== dram_bus.dram_addr_o || we0 !== dram_bus.dram_we_o ||
                             s0 !== dram_bus.dram_wstrb_o || w0 !== dram_bus.dram_wdata_o) begin
                    moved = 1'b1;
                end
                dram_bus.dram_ack_i = (reqs == s.ack_at);
                reqs++;
            end else begin
                dram_bus.dram_ack_i = 1'b0;
            end
            if (stall_req_o) begin
                stalls++;
            end else begin
                done = 1'b1;
                if (exp_q.size() == 0) begin
                    check_eq({tag, "_sb_empty"}, 32'd0, 32'd1);
                end else begin
                    got = exp_q.pop_front();
                    check_eq({tag, "_stalls"}, 32'(stalls), 32'(got.stalls));
                    check_eq({tag, "_req_cycles"}, 32'(reqs), 32'(got.reqs));
                    check_eq({tag, "_rd"}, 32'(rd_addr_o), 32'(got.rd));
                    check_eq({tag, "_wreg"}, 32'(wreg_o), 32'(got.wreg));
                    check_eq({tag, "_exc"}, 32'(mem_exc_o), 32'(got.exc));
                    check_eq({tag, "_fwd_rd"}, 32'(mem_back_rd_addr_o), 32'(got.rd));
                    check_eq({tag, "_fwd_wreg"}, 32'(mem_back_wreg_o), 32'(got.wreg));
                    if (got.wreg) begin
                        check_eq({tag, "_wdata"}, wdata_o, got.wdata);
                        check_eq({tag, "_fwd_wdata"}, mem_back_wdata_o, got.wdata);
                    end
                    if (got.bus) begin
                        check_eq({tag, "_daddr"}, a0, got.daddr);
                        check_eq({tag, "_dwe"}, 32'(we0), 32'(got.dwe));
                        check_eq({tag, "_dstrb"}, 32'(s0), 32'(got.dstrb));
                        check_eq({tag, "_bus_stable"}, 32'(moved), 32'd0);
                        if (got.chk_dwdata)
                            check_eq({tag, "_dwdata"}, w0, got.dwdata);
                    end
                end
            end
        end
        if (!done)
            check_eq({tag, "_no_release"}, 32'd0, 32'd1);
        dram_bus.dram_ack_i = 1'b0;
        if (gap) begin
            @(posedge clk); #1;
            mem_req_i = 1'b0; wreg_i = 1'b0;
            @(negedge clk);
            check_eq({tag, "_exc_pulse"}, 32'(mem_exc_o), 32'd0);
            check_eq({tag, "_idle_req"}, 32'(dram_bus.dram_req_o), 32'd0);
        end
    endtask

    initial begin
        bit seen;
        rst = 1'b0;
        mem_req_i = 1'b0; mem_we_i = 1'b0; funct3_i = 3'b000; addr_i = '0;
        store_data_i = '0; rd_addr_i = 5'd3; wreg_i = 1'b1; wdata_i = 32'h0000_00AA;
        dram_bus.dram_ack_i = 1'b0; dram_bus.dram_rdata_i = '0;

        // Reset values; passthrough follows inputs except wreg.
        #12;
        check_eq("rst_req", 32'(dram_bus.dram_req_o), 32'd0);
        check_eq("rst_we", 32'(dram_bus.dram_we_o), 32'd0);
        check_eq("rst_strb", 32'(dram_bus.dram_wstrb_o), 32'd0);
        check_eq("rst_addr", dram_bus.dram_addr_o, 32'd0);
        check_eq("rst_exc", 32'(mem_exc_o), 32'd0);
        check_eq("rst_stall", 32'(stall_req_o), 32'd0);
        check_eq("rst_wreg", 32'(wreg_o), 32'd0);
        check_eq("rst_rd", 32'(rd_addr_o), 32'd3);
        check_eq("rst_wdata", wdata_o, 32'h0000_00AA);
        @(negedge clk); rst = 1'b1;

        run_op("pass", mk_stim(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd5, 1'b1, 32'h1234, 32'h0, -1),
               mk_exp(0, 0, 5'd5, 1'b1, 32'h1234, 2'b00), 1'b1);
        run_op("lb", mk_stim(1'b1, 1'b0, 3'b000, 32'h1003, 32'h0, 5'd7, 1'b1, 32'hDEAD_0000, 32'h80FF_FF7F, 2),
               with_bus(mk_exp(4, 3, 5'd7, 1'b1, 32'hFFFF_FF80, 2'b00), 32'h1000, 1'b0, 4'b0000, 1'b0, 32'h0), 1'b1);
        run_op("lbu", mk_stim(1'b1, 1'b0, 3'b100, 32'h1003, 32'h0, 5'd7, 1'b1, 32'hDEAD_0000, 32'h80FF_FF7F, 2),
               with_bus(mk_exp(4, 3, 5'd7, 1'b1, 32'h0000_0080, 2'b00), 32'h1000, 1'b0, 4'b0000, 1'b0, 32'h0), 1'b1);
        run_op("sh", mk_stim(1'b1, 1'b1, 3'b001, 32'h2002, 32'hAAAA_BEEF, 5'd0, 1'b1, 32'h0, 32'h0, 0),
               with_bus(mk_exp(2, 1, 5'd0, 1'b0, 32'h0, 2'b00), 32'h2000, 1'b1, 4'b1100, 1'b1, 32'hBEEF_BEEF), 1'b1);
        run_op("lw_mis", mk_stim(1'b1, 1'b0, 3'b010, 32'h3001, 32'h0, 5'd9, 1'b1, 32'h55, 32'h0, -1),
               mk_exp(0, 0, 5'd9, 1'b0, 32'h0, 2'b01), 1'b1);
        run_op("lh_mis", mk_stim(1'b1, 1'b0, 3'b001, 32'h3001, 32'h0, 5'd9, 1'b1, 32'h55, 32'h0, -1),
               mk_exp(0, 0, 5'd9, 1'b0, 32'h0, 2'b01), 1'b1);
        run_op("ld_f3_011", mk_stim(1'b1, 1'b0, 3'b011, 32'h3000, 32'h0, 5'd9, 1'b1, 32'h55, 32'h0, -1),
               mk_exp(0, 0, 5'd9, 1'b0, 32'h0, 2'b11), 1'b1);
        run_op("ld_f3_prio", mk_stim(1'b1, 1'b0, 3'b110, 32'h3003, 32'h0, 5'd9, 1'b1, 32'h55, 32'h0, -1),
               mk_exp(0, 0, 5'd9, 1'b0, 32'h0, 2'b11), 1'b1);
        run_op("st_f3_100", mk_stim(1'b1, 1'b1, 3'b100, 32'h3000, 32'h0, 5'd9, 1'b0, 32'h55, 32'h0, -1),
               mk_exp(0, 0, 5'd9, 1'b0, 32'h0, 2'b11), 1'b1);
        run_op("timeout", mk_stim(1'b1, 1'b0, 3'b010, 32'h5000, 32'h0, 5'd10, 1'b1, 32'h0, 32'h0, -1),
               with_bus(mk_exp(TMO + 2, TMO + 1, 5'd10, 1'b0, 32'h0, 2'b10), 32'h5000, 1'b0, 4'b0000, 1'b0, 32'h0), 1'b1);
        run_op("lhu", mk_stim(1'b1, 1'b0, 3'b101, 32'h6002, 32'h0, 5'd11, 1'b1, 32'h0, 32'h8001_7FFF, 1),
               with_bus(mk_exp(3, 2, 5'd11, 1'b1, 32'h0000_8001, 2'b00), 32'h6000, 1'b0, 4'b0000, 1'b0, 32'h0), 1'b1);
        run_op("lh", mk_stim(1'b1, 1'b0, 3'b001, 32'h6000, 32'h0, 5'd11, 1'b1, 32'h0, 32'h1234_8765, 0),
               with_bus(mk_exp(2, 1, 5'd11, 1'b1, 32'hFFFF_8765, 2'b00), 32'h6000, 1'b0, 4'b0000, 1'b0, 32'h0), 1'b1);
        // sb then sw with no idle gap between them.
        run_op("sb", mk_stim(1'b1, 1'b1, 3'b000, 32'h7001, 32'h0000_00A5, 5'd0, 1'b0, 32'h0, 32'h0, 1),
               with_bus(mk_exp(3, 2, 5'd0, 1'b0, 32'h0, 2'b00), 32'h7000, 1'b1, 4'b0010, 1'b1, 32'hA5A5_A5A5), 1'b0);
        run_op("sw", mk_stim(1'b1, 1'b1, 3'b010, 32'h7004, 32'hCAFE_F00D, 5'd0, 1'b0, 32'h0, 32'h0, 0),
               with_bus(mk_exp(2, 1, 5'd0, 1'b0, 32'h0, 2'b00), 32'h7004, 1'b1, 4'b1111, 1'b1, 32'hCAFE_F00D), 1'b1);
        run_op("lw", mk_stim(1'b1, 1'b0, 3'b010, 32'h8000, 32'h0, 5'd12, 1'b1, 32'h0, 32'h1357_9BDF, 0),
               with_bus(mk_exp(2, 1, 5'd12, 1'b1, 32'h1357_9BDF, 2'b00), 32'h8000, 1'b0, 4'b0000, 1'b0, 32'h0), 1'b1);

        // Reset while the bus request is outstanding.
        @(posedge clk); #1;
        mem_req_i = 1'b1; mem_we_i = 1'b0; funct3_i = 3'b010; addr_i = 32'hA000;
        rd_addr_i = 5'd13; wreg_i = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 5 && !seen; c++) begin
            @(negedge clk);
            seen = dram_bus.dram_req_o;
        end
        check_eq("midreq_seen", 32'(seen), 32'd1);
        rst = 1'b0;
        #1;
        check_eq("midreq_rst_req", 32'(dram_bus.dram_req_o), 32'd0);
        check_eq("midreq_rst_stall", 32'(stall_req_o), 32'd0);
        check_eq("midreq_rst_wreg", 32'(wreg_o), 32'd0);
        mem_req_i = 1'b0;
        @(negedge clk); rst = 1'b1;

        run_op("lw_after_rst", mk_stim(1'b1, 1'b0, 3'b010, 32'h9000, 32'h0, 5'd14, 1'b1, 32'h0, 32'h0BAD_F00D, 0),
               with_bus(mk_exp(2, 1, 5'd14, 1'b1, 32'h0BAD_F00D, 2'b00), 32'h9000, 1'b0, 4'b0000, 1'b0, 32'h0), 1'b1);

        check_eq("sb_leftover", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
